rr_decoder_arbiter: RTL

- Round-robin arbiter sharing one resource among 2**N requesters.
- Selects one requester, registers its index and drives a one-hot grant vector through the team's parameterised one-hot decoder.
- Holds the grant until the owner releases it, drops its request, or exceeds a hold limit.
- Sits in front of any shared datapath whose select is a one-hot vector decoded from an N-bit index.

---
 rtl/rr_decoder_arbiter_pkg.sv | 31 +++
 rtl/rr_decoder_arbiter_if.sv | 16 +
 rtl/rr_decoder_arbiter_dec.sv | 12 +
 rtl/rr_decoder_arbiter.sv | 76 +++++++
 4 files changed

// File: rtl/rr_decoder_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the decoder arbiter.
// rr_pick is sized for up to MAX_N index bits; callers zero-extend their vectors.
package arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam int MAX_N   = 6;
  localparam int REQ_MAX = 2 ** MAX_N;

  // First set bit of req at or above ptr, wrapping modulo 2**n.
  function automatic logic [MAX_N-1:0] rr_pick(input logic [REQ_MAX-1:0] req,
                                               input logic [MAX_N-1:0]   ptr,
                                               input int unsigned        n);
    int unsigned cnt;
    int unsigned j;
    logic        found;
    logic [MAX_N-1:0] win;
    cnt   = 32'd1 << n;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < REQ_MAX; k++) begin
      j = (32'(ptr) + k) & (cnt - 32'd1);
      if (!found && (k < cnt) && req[j[MAX_N-1:0]]) begin
        found = 1'b1;
        win   = j[MAX_N-1:0];
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_decoder_arbiter_if.sv
// Requester-side bus of the arbiter. Handshake: a requester holds req[i] until it
// sees grant[i]; the owner keeps req high while using the resource and may pulse done.
interface rr_decoder_arbiter_if #(parameter int N = 3) ();
  logic [2**N-1:0]   req;
  logic              done;
  logic [2**N-1:0]   grant;
  logic [N-1:0]      grant_idx;
  logic              grant_valid;
  logic              expired;
  arb_pkg::state_t   state;

  modport slave  (input req, done,
                  output grant, grant_idx, grant_valid, expired, state);
  modport master (output req, done,
                  input grant, grant_idx, grant_valid, expired, state);
endinterface

// File: rtl/rr_decoder_arbiter_dec.sv
// Parameterised one-hot decoder: y has exactly bit a set.
module onehot_decoder #(
  parameter int N = 3
) (
  input  logic [N-1:0]    a,
  output logic [2**N-1:0] y
);
  always_comb begin
    y    = '0;
    y[a] = 1'b1;
  end
endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter over 2**N requesters with done/drop/hold-limit release.
// All outputs come from registers; grant is the decoded owner index gated by grant_valid.
module rr_decoder_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 3,
  parameter int HOLD_MAX = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  rr_decoder_arbiter_if.slave   bus
);
  localparam int R  = 2 ** N;
  localparam int CW = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);

  state_t         state;
  logic [N-1:0]   idx;
  logic [N-1:0]   ptr;
  logic [N-1:0]   winner;
  logic [CW-1:0]  hold;
  logic           valid;
  logic           expired;
  logic           limit_hit;
  logic           release_now;
  logic [R-1:0]   dec_y;

  assign winner      = N'(rr_pick(REQ_MAX'(bus.req), MAX_N'(ptr), N));
  assign limit_hit   = (HOLD_MAX != 0) && (hold == CW'(HOLD_MAX));
  assign release_now = bus.done || !bus.req[idx] || limit_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      valid   <= 1'b0;
      idx     <= '0;
      ptr     <= '0;
      hold    <= '0;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state <= BUSY;
            valid <= 1'b1;
            idx   <= winner;
            hold  <= CW'(1);
          end
        end
        BUSY: begin
          if (release_now) begin
            state   <= IDLE;
            valid   <= 1'b0;
            ptr     <= idx + 1'b1;
            // Only a pure timeout counts as expiry; done or a dropped request wins.
            expired <= limit_hit && !bus.done && bus.req[idx];
          end else if (hold != {CW{1'b1}}) begin
            hold <= hold + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  onehot_decoder #(.N(N)) u_dec (
    .a (idx),
    .y (dec_y)
  );

  assign bus.grant       = dec_y & {R{valid}};
  assign bus.grant_idx   = idx;
  assign bus.grant_valid = valid;
  assign bus.expired     = expired;
  assign bus.state       = state;
endmodule
